// File: rtl/adder_pkg.sv
// Shared widths and the word type for the 32-bit registered adder and its lookahead groups.
package adder_pkg;

  localparam int ADDER_WIDTH = 32;
  localparam int CLA_GROUP   = 4;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead block: local sum bits plus group generate/propagate
// for the second-level carry unit.
module cla_group
  import adder_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             G,
  output logic             P
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;
  logic             c_prod;
  logic             g_prod;

  assign g = a & b;
  assign p = a ^ b;

  // Each bit carry is a flat sum of products: c[i] = cin.p[0..i-1] + sum_j g[j].p[j+1..i-1].
  always_comb begin
    c      = '0;
    c_prod = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      c_prod = cin;
      for (int k = 0; k < i; k++) begin
        c_prod = c_prod & p[k];
      end
      c[i] = c_prod;
      for (int j = 0; j < i; j++) begin
        c_prod = g[j];
        for (int k = j + 1; k < i; k++) begin
          c_prod = c_prod & p[k];
        end
        c[i] = c[i] | c_prod;
      end
    end
  end

  // Kept separate from the carry logic so G/P never depend on cin.
  always_comb begin
    G      = 1'b0;
    g_prod = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      g_prod = g[j];
      for (int k = j + 1; k < GROUP; k++) begin
        g_prod = g_prod & p[k];
      end
      G = G | g_prod;
    end
  end

  assign P   = &p;
  assign sum = p ^ c;

endmodule

// File: rtl/adder_32.sv
// Registered adder: lookahead groups, an inline second-level carry unit, and an
// output register holding sum, carry-out and signed overflow.
module adder_32
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NGROUPS = WIDTH / GROUP;

  logic [NGROUPS-1:0] grp_g;
  logic [NGROUPS-1:0] grp_p;
  logic [NGROUPS:0]   grp_c;
  logic               carry_in;
  logic               l2_prod;
  logic [WIDTH-1:0]   sum_comb;

  logic [WIDTH-1:0]   s_d, s_q;
  logic               cout_d, cout_q;
  logic               ovf_d, ovf_q;

  assign carry_in = 1'b0;

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
    cla_group #(
      .GROUP(GROUP)
    ) u_grp (
      .a  (A[gi*GROUP +: GROUP]),
      .b  (B[gi*GROUP +: GROUP]),
      .cin(grp_c[gi]),
      .sum(sum_comb[gi*GROUP +: GROUP]),
      .G  (grp_g[gi]),
      .P  (grp_p[gi])
    );
  end

  // Group carry-ins from group G/P; grp_c[NGROUPS] is the carry out of the MSB.
  always_comb begin
    grp_c   = '0;
    l2_prod = 1'b0;
    for (int i = 0; i <= NGROUPS; i++) begin
      l2_prod = carry_in;
      for (int k = 0; k < i; k++) begin
        l2_prod = l2_prod & grp_p[k];
      end
      grp_c[i] = l2_prod;
      for (int j = 0; j < i; j++) begin
        l2_prod = grp_g[j];
        for (int k = j + 1; k < i; k++) begin
          l2_prod = l2_prod & grp_p[k];
        end
        grp_c[i] = grp_c[i] | l2_prod;
      end
    end
  end

  assign s_d    = sum_comb;
  assign cout_d = grp_c[NGROUPS];
  assign ovf_d  = (A[WIDTH-1] == B[WIDTH-1]) && (sum_comb[WIDTH-1] != A[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_adder_32.sv
// Self-checking bench for adder_32: directed literal vectors, async reset cases,
// and a per-cycle arithmetic reference model over random back-to-back pairs.
module tb_adder_32;
  import adder_pkg::*;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b1;
  word_t A     = '0;
  word_t B     = '0;
  word_t S;
  logic  Cout;
  logic  Ovf;

  int tests = 0;
  int fails = 0;

  adder_32 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .S    (S),
    .Cout (Cout),
    .Ovf  (Ovf)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: {ovf, cout, sum} from plain 64-bit integer maths.
  function automatic logic [33:0] ref_add(input word_t a, input word_t b);
    longint unsigned u;
    longint          sg;
    logic            o;
    u  = {32'd0, a} + {32'd0, b};
    sg = longint'($signed(a)) + longint'($signed(b));
    o  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
    return {o, u[32], u[31:0]};
  endfunction

  word_t m_s = '0;
  logic  m_c = 1'b0;
  logic  m_o = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s <= '0;
      m_c <= 1'b0;
      m_o <= 1'b0;
    end else begin
      {m_o, m_c, m_s} <= ref_add(A, B);
    end
  end

  always @(negedge clk) begin
    tests++;
    if ({S, Cout, Ovf} !== {m_s, m_c, m_o}) begin
      fails++;
      $display("FAIL model_cmp t=%0t A=%h B=%h got S=%h C=%b O=%b exp S=%h C=%b O=%b",
               $time, A, B, S, Cout, Ovf, m_s, m_c, m_o);
    end
  end

  task automatic check(input string nm, input word_t es, input logic ec, input logic eo);
    tests++;
    if ({S, Cout, Ovf} !== {es, ec, eo}) begin
      fails++;
      $display("FAIL %s got S=%h C=%b O=%b exp S=%h C=%b O=%b", nm, S, Cout, Ovf, es, ec, eo);
    end else begin
      $display("[TB] %s S=%h C=%b O=%b ok", nm, S, Cout, Ovf);
    end
  endtask

  task automatic apply(input string nm, input word_t a, input word_t b,
                       input word_t es, input logic ec, input logic eo);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1 check(nm, es, ec, eo);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    A = 32'd5;
    B = 32'd7;
    #1 check("reset_immediate", 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("reset_held", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release", 32'd12, 1'b0, 1'b0);

    apply("small_45_27",  32'd45, 32'd27,  32'd72,  1'b0, 1'b0);
    apply("small_33_142", 32'd33, 32'd142, 32'd175, 1'b0, 1'b0);
    apply("zero_0_0",     32'd0,  32'd0,   32'd0,   1'b0, 1'b0);
    apply("wrap",         32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
    apply("ovf_pos",      32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    apply("ovf_neg",      32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b1);
    apply("grp_chain",    32'h0000_FFFF, 32'h1, 32'h0001_0000, 1'b0, 1'b0);
    apply("alt_bits",     32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0);
    apply("mid_value",    32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);

    // Reset dropped between edges must clear outputs before the next edge.
    #2 rst_n = 1'b0;
    #1 check("async_midstream", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    A = 32'd100;
    B = 32'd200;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_async", 32'd300, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      A = $urandom;
      B = $urandom;
    end
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
